rotate_seq: RTL and testbench
=============================

Name: rotate_seq

Overview:
- Sequencer that sits directly upstream of the parameterised right-rotate register.
- Accepts a word and a rotate amount over a valid/ready handshake.
- Drives the register's load/shift controls and data input for the required number of cycles.
- Reads the register's output back and presents the rotated word over a valid/ready output handshake.

Parameters:
- bit_width, 16, word width; must match the attached rotate register.
- amt_width, 5, width of the rotate-amount field; values up to 2^amt_width-1 accepted.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_data  input  bit_width  word to rotate.
- in_amt  input  amt_width  number of single-bit right rotations.
- ld  output  1  load strobe to the rotate register.
- sh  output  1  shift strobe to the rotate register.
- rot_data_in  output  bit_width  data to the rotate register's load input.
- rot_data_out  input  bit_width  registered output of the rotate register.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  bit_width  rotated result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Rotate register semantics (per cycle):
  - ld=1, sh=0: load data.
  - ld=1, sh=1: load data rotated right by 1.
  - ld=0, sh=1: rotate stored value right by 1.
  - ld=0, sh=0: hold.
  - Rotation direction: bit0 moves to the MSB.
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; ld=0; sh=0; out_valid=0; busy=0; rot_data_in=0; counter=0; captured amount=0. Reset mid-operation abandons the request with no output. The rotate register's own reset is handled at top level.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into rot_data_in and in_amt into the amount register; go to LOAD.
- LOAD (always exactly 1 cycle):
  - ld=1, sh=(amt!=0).
  - If amt<=1, go to DONE; else load counter=amt-2 and go to SHIFT.
- SHIFT:
  - ld=0, sh=1.
  - If counter==0, go to DONE; else decrement the counter.
  - Total sh-high cycles across LOAD and SHIFT equal amt exactly.
- DONE:
  - ld=0, sh=0, so the register holds.
  - out_valid=1; out_data=rot_data_out (combinational pass-through; stable because the register is holding).
  - On out_ready go to IDLE. out_valid may stay high indefinitely under backpressure.
- in_ready=0 in every state except IDLE; requests presented while busy are ignored, not queued.
- Latency from the accept edge to the first out_valid-high cycle is max(amt,1)+1 cycles. Examples: amt=0 gives 2, amt=1 gives 2, amt=5 gives 6.
- Result: out_data = in_data rotated right by (amt mod bit_width). Amounts >= bit_width still cost amt shift cycles unless the optional feature is on.
- Back-to-back operation: the DONE->IDLE handshake cycle and the next IDLE accept are separate cycles, so throughput is at most one request per max(amt,1)+2 cycles.
- The counter never wraps: the SHIFT exit is tested before any decrement.

Optional Feature:
- Macro: ROTATE_SEQ_AMT_MOD_EN.
- Defined: the amount is reduced modulo bit_width at capture. amt=bit_width behaves as amt=0 (latency 2); amt=bit_width+3 behaves as 3.
- Not defined: the amount is used literally. amt=bit_width takes bit_width sh cycles and returns in_data unchanged.
- Result values are identical either way; only latency differs.

Decomposition:
- Package rotate_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE), 2-bit encoding.
  - default bit_width / amt_width constants.
  - amount-to-first-counter-value helper constant.
- Sub-module rotate_cnt: down-counter with load, enable and zero flag, amt_width bits. It is the natural split; the FSM stays in rotate_seq.

Test Plan:
- Reset mid-SHIFT: accept in_data=16'h8001, amt=7; pull rst low in SHIFT -> ld=sh=out_valid=0 immediately, in_ready=1, no output appears.
- amt=0: in_data=16'hA5C3 -> one LOAD cycle with ld=1, sh=0; out_valid 2 cycles after accept; out_data=16'hA5C3.
- amt=1: in_data=16'h0001 -> LOAD with ld=1, sh=1; out_valid at accept+2; out_data=16'h8000.
- amt=4: in_data=16'h1234 -> sh high for exactly 4 cycles; out_data=16'h4123; out_valid at accept+5.
- Backpressure: amt=3, out_ready held 0 for 10 cycles -> out_valid and out_data stable, ld=sh=0, in_valid ignored; release -> IDLE next cycle.
- amt=16, data=16'hBEEF:
  - Macro off: 16 sh cycles, out_data=16'hBEEF, latency 17.
  - Macro on: 0 sh cycles, latency 2, out_data=16'hBEEF.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate sequencer.
// Sequencer state encoding, default widths and the counter preload offset.
package rotate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned BIT_WIDTH_DEF = 16;
    localparam int unsigned AMT_WIDTH_DEF = 5;

    // LOAD contributes one shift and the final SHIFT cycle another, so the
    // counter starts at amt-2 and SHIFT exits when it reads zero.
    localparam int unsigned CNT_OFFSET = 2;

endpackage

// File: rtl/rotate_cnt.sv
// Down-counter with synchronous load, count enable and zero flag.
// Used by rotate_seq to pace the SHIFT state.
module rotate_cnt #(
    parameter int unsigned width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [width-1:0] load_val,
    output logic             zero
);

    logic [width-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - width'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rotate_seq.sv
// Sequencer driving a right-rotate register via ld/sh strobes over valid/ready.
// Optional macro ROTATE_SEQ_AMT_MOD_EN reduces the amount modulo bit_width at capture.
module rotate_seq
    import rotate_pkg::*;
#(
    parameter int unsigned bit_width = BIT_WIDTH_DEF,
    parameter int unsigned amt_width = AMT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] in_data,
    input  logic [amt_width-1:0] in_amt,
    output logic                 ld,
    output logic                 sh,
    output logic [bit_width-1:0] rot_data_in,
    input  logic [bit_width-1:0] rot_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_width-1:0] out_data,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic [amt_width-1:0] amt_q;
    logic [amt_width-1:0] amt_cap;
    logic [amt_width-1:0] cnt_load_val;
    logic                 accept;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_zero;

`ifdef ROTATE_SEQ_AMT_MOD_EN
    assign amt_cap = amt_width'(32'(in_amt) % 32'(bit_width));
`else
    assign amt_cap = in_amt;
`endif

    assign cnt_load_val = amt_q - amt_width'(CNT_OFFSET);

    rotate_cnt #(
        .width(amt_width)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amt_q       <= '0;
            rot_data_in <= '0;
        end else if (accept) begin
            amt_q       <= amt_cap;
            rot_data_in <= in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        ld        = 1'b0;
        sh        = 1'b0;
        out_valid = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld = 1'b1;
                sh = (amt_q != '0);
                if (amt_q <= amt_width'(1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sh = 1'b1;
                // Exit is tested before decrementing so the counter never wraps.
                if (cnt_zero) begin
                    state_nxt = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_data = rot_data_out;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rotate_seq.sv
// Self-checking bench for rotate_seq with a behavioural rotate register attached.
// Honours ROTATE_SEQ_AMT_MOD_EN for expected latency/shift counts.
module tb_rotate_seq;

    localparam int unsigned W = 16;
    localparam int unsigned A = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [A-1:0] in_amt = '0;
    logic         ld;
    logic         sh;
    logic [W-1:0] rot_data_in;
    logic [W-1:0] rot_data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    rotate_seq #(
        .bit_width(W),
        .amt_width(A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amt       (in_amt),
        .ld           (ld),
        .sh           (sh),
        .rot_data_in  (rot_data_in),
        .rot_data_out (rot_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    // Attached rotate register, reset together with the sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rot_data_out <= '0;
        else if (ld && sh) rot_data_out <= {rot_data_in[0], rot_data_in[W-1:1]};
        else if (ld) rot_data_out <= rot_data_in;
        else if (sh) rot_data_out <= {rot_data_out[0], rot_data_out[W-1:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotr_ref(input logic [W-1:0] x, input int unsigned amt);
        int unsigned k;
        logic [31:0] wide;
        k = amt % W;
        wide = (32'(x) >> k) | (32'(x) << (W - k));
        return wide[W-1:0];
    endfunction

    function automatic int unsigned eff_amt(input int unsigned amt);
`ifdef ROTATE_SEQ_AMT_MOD_EN
        return amt % W;
`else
        return amt;
`endif
    endfunction

    task automatic do_req(input logic [W-1:0] data, input int unsigned amt, input int unsigned hold);
        int unsigned ea;
        int unsigned lat;
        int unsigned sh_cnt;
        int unsigned exp_lat;
        logic [W-1:0] exp_out;
        ea = eff_amt(amt);
        exp_lat = ((ea > 0) ? ea : 1) + 1;
        exp_out = rotr_ref(data, amt);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = data;
        in_amt = A'(amt);
        out_ready = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Keep offering garbage requests while busy; they must be ignored.
        in_data = W'($urandom);
        in_amt = A'($urandom);
        lat = 1;
        sh_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (lat == 1) begin
                check("load_ld", 32'(ld), 32'd1);
                check("load_sh", 32'(sh), 32'(ea != 0));
            end else begin
                if (ld) check("shift_ld", 32'(ld), 32'd0);
            end
            if (in_ready) check("busy_in_ready", 32'(in_ready), 32'd0);
            if (sh) sh_cnt++;
            lat++;
            @(negedge clk);
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", lat, exp_lat);
        check("sh_cycles", sh_cnt, ea);
        check("out_data", 32'(out_data), 32'(exp_out));
        check("data_captured", 32'(rot_data_in), 32'(data));
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_out || ld || sh || in_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(exp_out));
                check("hold_ldsh", 32'({ld, sh, in_ready}), 32'd0);
            end
        end
        if (hold > 0) check("hold_end_data", 32'(out_data), 32'(exp_out));
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("back_idle_busy", 32'(busy), 32'd0);
        check("back_idle_ready", 32'(in_ready), 32'd1);
        check("back_idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ov_seen;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ld", 32'(ld), 32'd0);
        check("rst_sh", 32'(sh), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rot_data_in", 32'(rot_data_in), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of SHIFT abandons the request.
        in_valid = 1'b1;
        in_data = 16'h8001;
        in_amt = 5'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_shift_sh", 32'(sh), 32'd1);
        check("mid_shift_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_ld", 32'(ld), 32'd0);
        check("arst_sh", 32'(sh), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("arst_no_output", ov_seen, 0);

        do_req(16'hA5C3, 0, 0);
        do_req(16'h0001, 1, 0);
        do_req(16'h1234, 4, 0);
        do_req(16'hF00D, 3, 10);
        do_req(16'hBEEF, 16, 0);
        do_req(16'h1357, 19, 2);
        do_req(16'hC0DE, 31, 1);

        for (int n = 0; n < 25; n++) begin
            do_req(W'($urandom), $urandom_range(0, 31), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
